rom_programmer: RTL and testbench

- Programming (fuse-burning) sequencer for 556PT5 (3604, 512x8) and 556PT4 (3601, 256x4) bipolar PROMs; the write-side counterpart of the chip reader.
- Accepts one address/data word per command, then sets the address and fires pulses on one output bit at a time.
- After each pulse it reads the word back to verify, retrying up to a limit, and returns a status response.
- Sits between the host command path (UART/button front end) and the PROM socket driver pins.

---
 rtl/rom_prog_pkg.sv | 44 ++++
 rtl/rom_prog_timer.sv | 27 ++
 rtl/rom_programmer.sv | 184 ++++++++++++++++++
 tb/tb_rom_programmer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_prog_pkg.sv
// Shared types, pin constants, chip presets and helpers for the bipolar PROM
// programming sequencer.
package rom_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_PULSE,
        ST_RECOVER,
        ST_RESPOND
    } state_e;

    // V1..V4 supply selects, bit0 = V1
    localparam logic [3:0] OP_READ = 4'b1100;
    localparam logic [3:0] OP_PROG = 4'b0011;

    localparam logic [1:0] STATUS_OK        = 2'd0;
    localparam logic [1:0] STATUS_BAD_ADDR  = 2'd1;
    localparam logic [1:0] STATUS_OVERBLOWN = 2'd2;
    localparam logic [1:0] STATUS_NO_BURN   = 2'd3;

    localparam int P3604_DATA_WIDTH    = 8;
    localparam int P3604_ADDRESS_WIDTH = 9;
    localparam int P3604_MAX_ADDRESS   = 511;
    localparam int P3601_DATA_WIDTH    = 4;
    localparam int P3601_ADDRESS_WIDTH = 8;
    localparam int P3601_MAX_ADDRESS   = 255;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set_bit(input logic [15:0] v);
        lowest_set_bit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set_bit = 4'(i);
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rom_prog_timer.sv
// Loadable down-counter with a terminal-count flag; one instance times the
// settle, pulse and recover windows.
module rom_prog_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/rom_programmer.sv
// Fuse-burning sequencer for 556PT5/556PT4 PROMs: one address/data word per
// command, bit-by-bit pulse and verify, status response.
//   state   | meaning
//   IDLE    | cmd_ready high, waiting for a command
//   SETTLE  | address stable with read op, SETTLE_CYCLES clocks
//   SAMPLE  | capture data_line_in, decide done / fail / next pulse
//   PULSE   | one-hot prog_bit with OP_PROG, PULSE_CYCLES clocks
//   RECOVER | read op, prog_bit low, RECOVER_CYCLES clocks
//   RESPOND | rsp_valid held until rsp_ready
// Latency from the accept edge to rsp_valid is exactly
// (n+1)*(SETTLE_CYCLES+1) + n*(PULSE_CYCLES+RECOVER_CYCLES) clocks for n pulses;
// a bad address raises rsp_valid on the accept edge itself.
module rom_programmer
    import rom_prog_pkg::*;
#(
    parameter int DATA_WIDTH     = P3604_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = P3604_ADDRESS_WIDTH,
    parameter int MAX_ADDRESS    = P3604_MAX_ADDRESS,
    parameter int SETTLE_CYCLES  = 16,
    parameter int PULSE_CYCLES   = 64,
    parameter int RECOVER_CYCLES = 32,
    parameter int MAX_ATTEMPTS   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    prog_bit,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_status,
    output logic [DATA_WIDTH-1:0]    rsp_readback
);

    localparam int TW = $clog2(max3(SETTLE_CYCLES, PULSE_CYCLES, RECOVER_CYCLES)) + 1;
    localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] RECOVER_LOAD = TW'(RECOVER_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH:0] MAX_ADDR_X = (ADDRESS_WIDTH + 1)'(MAX_ADDRESS);

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    target_q;
    logic [DATA_WIDTH-1:0]    prog_q;
    logic [DATA_WIDTH-1:0]    readback_q;
    logic [3:0]               op_q;
    logic [3:0]               attempts_q;
    logic [3:0]               bit_q;
    logic                     bit_valid_q;
    logic                     cmd_ready_q;
    logic                     rsp_valid_q;
    logic [1:0]               status_q;

    logic                     timer_load_d;
    logic [TW-1:0]            timer_value_d;
    logic                     timer_zero;
    logic [DATA_WIDTH-1:0]    over_bits;
    logic [DATA_WIDTH-1:0]    need_bits;
    logic [3:0]               sel_bit;
    logic [3:0]               attempts_d;
    logic                     addr_bad;

    assign over_bits  = data_line_in & ~target_q;
    assign need_bits  = target_q & ~data_line_in;
    assign sel_bit    = lowest_set_bit(16'(need_bits));
    // The retry budget restarts whenever verification moves on to another bit.
    assign attempts_d = (bit_valid_q && sel_bit == bit_q) ? attempts_q : 4'd0;
    assign addr_bad   = {1'b0, cmd_address} > MAX_ADDR_X;

    // Reload the timer with the length of whichever timed state comes next.
    always_comb begin
        timer_load_d  = 1'b0;
        timer_value_d = SETTLE_LOAD;
        case (state_q)
            ST_IDLE:    timer_load_d = 1'b1;
            ST_SAMPLE: begin
                timer_load_d  = 1'b1;
                timer_value_d = PULSE_LOAD;
            end
            ST_PULSE: begin
                timer_load_d  = timer_zero;
                timer_value_d = RECOVER_LOAD;
            end
            ST_RECOVER: timer_load_d = timer_zero;
            default:    timer_load_d = 1'b0;
        endcase
    end

    rom_prog_timer #(.WIDTH(TW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (timer_load_d),
        .value_i (timer_value_d),
        .zero_o  (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            address_q   <= '0;
            target_q    <= '0;
            prog_q      <= '0;
            readback_q  <= '0;
            op_q        <= OP_READ;
            attempts_q  <= 4'd0;
            bit_q       <= 4'd0;
            bit_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            status_q    <= STATUS_OK;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_valid && cmd_ready_q) begin
                    target_q    <= cmd_data;
                    attempts_q  <= 4'd0;
                    bit_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    if (addr_bad) begin
                        status_q    <= STATUS_BAD_ADDR;
                        readback_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESPOND;
                    end else begin
                        address_q <= cmd_address;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: if (timer_zero) state_q <= ST_SAMPLE;
                ST_SAMPLE: begin
                    readback_q <= data_line_in;
                    if (over_bits != '0) begin
                        status_q    <= STATUS_OVERBLOWN;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESPOND;
                    end else if (data_line_in == target_q) begin
                        status_q    <= STATUS_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESPOND;
                    end else begin
                        bit_q       <= sel_bit;
                        bit_valid_q <= 1'b1;
                        if (attempts_d == 4'(MAX_ATTEMPTS)) begin
                            attempts_q  <= attempts_d;
                            status_q    <= STATUS_NO_BURN;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESPOND;
                        end else begin
                            attempts_q <= attempts_d + 4'd1;
                            prog_q     <= DATA_WIDTH'(1) << sel_bit;
                            op_q       <= OP_PROG;
                            state_q    <= ST_PULSE;
                        end
                    end
                end
                ST_PULSE: if (timer_zero) begin
                    prog_q  <= '0;
                    op_q    <= OP_READ;
                    state_q <= ST_RECOVER;
                end
                ST_RECOVER: if (timer_zero) state_q <= ST_SETTLE;
                ST_RESPOND: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign operation    = op_q;
    assign address_line = address_q;
    assign prog_bit     = prog_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = status_q;
    assign rsp_readback = readback_q;

endmodule

// File: tb/tb_rom_programmer.sv
// Scoreboard bench for rom_programmer: a behavioural PROM model feeds the
// verify reads, a reference model predicts pulses and responses.
module tb_rom_programmer;
    import rom_prog_pkg::*;

    localparam int DW = 8, AW = 10, MAXA = 511;
    localparam int S = 16, P = 64, R = 32, MA = 8;

    typedef struct {
        logic [1:0] status;
        logic [7:0] rb;
        int         lat;
        int         npulse;
    } exp_t;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [AW-1:0] cmd_address, address_line;
    logic [DW-1:0] cmd_data, data_line_in, prog_bit, rsp_readback;
    logic [3:0]    operation;
    logic [1:0]    rsp_status;

    logic          cmd_valid2, cmd_ready2, rsp_valid2;
    logic [8:0]    cmd_address2, address_line2;
    logic [3:0]    cmd_data2, prog_bit2, rsp_readback2, operation2;
    logic [1:0]    rsp_status2;
    logic [3:0]    data_line_in2 = 4'h0;
    logic          rsp_ready2 = 1'b1;

    int            checks = 0, failures = 0;
    exp_t          exp_q[$];
    int            exp_pulse_q[$];
    logic [7:0]    chip_word = 8'h00;
    logic [31:0]   burn_nib = 32'h0;
    int            pulse_cnt[8];
    logic [AW-1:0] exp_addr_line = '0;
    time           acc_time = 0;
    bit            prog2_seen = 1'b0;

    assign data_line_in = chip_word;

    always #5 clk = ~clk;

    rom_programmer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_ADDRESS(MAXA),
        .SETTLE_CYCLES(S), .PULSE_CYCLES(P), .RECOVER_CYCLES(R), .MAX_ATTEMPTS(MA)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .data_line_in(data_line_in),
        .operation(operation), .address_line(address_line), .prog_bit(prog_bit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_readback(rsp_readback));

    rom_programmer #(.DATA_WIDTH(4), .ADDRESS_WIDTH(9), .MAX_ADDRESS(255)) dut3601 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_address(cmd_address2), .cmd_data(cmd_data2), .data_line_in(data_line_in2),
        .operation(operation2), .address_line(address_line2), .prog_bit(prog_bit2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_status(rsp_status2),
        .rsp_readback(rsp_readback2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: fuses burn in ascending bit order, each needing its own pulse count.
    task automatic issue(input logic [AW-1:0] addr, input logic [7:0] data,
                         input logic [7:0] init, input logic [31:0] burns, input bit expect_rsp);
        exp_t       e;
        logic [7:0] word;
        int         n;
        bit         bad, stop;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'(cmd_ready), 1);
            return;
        end
        chip_word = init;
        burn_nib  = burns;
        for (int b = 0; b < 8; b++) pulse_cnt[b] = 0;
        bad  = (int'(addr) > MAXA);
        word = init;
        e.npulse = 0;
        e.status = STATUS_OK;
        if (bad) begin
            e.status = STATUS_BAD_ADDR;
            word     = 8'h00;
        end else if ((init & ~data) != 8'h00) begin
            e.status = STATUS_OVERBLOWN;
        end else begin
            stop = 1'b0;
            for (int b = 0; b < 8; b++) begin
                if (!stop && data[b] && !word[b]) begin
                    n = int'((burns >> (4 * b)) & 32'hF);
                    if (n == 0 || n > MA) begin
                        for (int k = 0; k < MA; k++) if (expect_rsp) exp_pulse_q.push_back(b);
                        e.npulse += MA;
                        e.status = STATUS_NO_BURN;
                        stop = 1'b1;
                    end else begin
                        for (int k = 0; k < n; k++) if (expect_rsp) exp_pulse_q.push_back(b);
                        e.npulse += n;
                        word[b] = 1'b1;
                    end
                end
            end
        end
        e.rb  = word;
        e.lat = bad ? -1 : (e.npulse + 1) * (S + 1) + e.npulse * (P + R);
        if (expect_rsp) exp_q.push_back(e);
        if (!bad) exp_addr_line = addr;
        cmd_address = addr;
        cmd_data    = data;
        cmd_valid   = 1'b1;
        acc_time    = $time + 10;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cmd_ready && !rsp_valid) && n < 20000);
        if (!(cmd_ready && !rsp_valid)) chk("done_timeout", 32'(cmd_ready), 1);
    endtask

    // Monitor: pulse windows, pin rules, chip model update, response scoreboard.
    initial begin : monitor
        bit         in_win = 1'b0, rsp_seen = 1'b0, pin_err = 1'b0;
        int         width = 0, pulse_seen = 0, idx, lat;
        logic [7:0] win_bit = 8'h00;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (prog_bit2 != 4'h0) prog2_seen = 1'b1;
            if (!reset_n) begin
                in_win = 1'b0; width = 0; pulse_seen = 0; pin_err = 1'b0; rsp_seen = 1'b0;
            end else begin
                if (prog_bit != 8'h00) begin
                    if (!in_win) begin
                        in_win = 1'b1; width = 0; win_bit = prog_bit;
                        if (!$onehot(prog_bit)) pin_err = 1'b1;
                    end
                    width++;
                    if (prog_bit != win_bit || operation != OP_PROG) pin_err = 1'b1;
                end else begin
                    if (operation != OP_READ) pin_err = 1'b1;
                    if (in_win) begin
                        in_win = 1'b0;
                        pulse_seen++;
                        idx = 0;
                        for (int b = 0; b < 8; b++) if (win_bit[b]) idx = b;
                        if (exp_pulse_q.size() == 0) chk("pulse_unexpected", 32'(idx), 32'hFFFF);
                        else chk("pulse_bit", 32'(idx), 32'(exp_pulse_q.pop_front()));
                        chk("pulse_width", 32'(width), 32'(P));
                        pulse_cnt[idx]++;
                        if (((burn_nib >> (4 * idx)) & 32'hF) != 0 &&
                            32'(pulse_cnt[idx]) >= ((burn_nib >> (4 * idx)) & 32'hF))
                            chip_word[idx] = 1'b1;
                    end
                end
                if (!cmd_ready && address_line != exp_addr_line) pin_err = 1'b1;
                if (rsp_valid && !rsp_seen) begin
                    rsp_seen = 1'b1;
                    lat = int'(($time - acc_time) / 10);
                    if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_status), 32'hFFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_status", 32'(rsp_status), 32'(e.status));
                        chk("rsp_readback", 32'(rsp_readback), 32'(e.rb));
                        if (e.lat < 0) chk("bad_addr_latency_le2", 32'(lat <= 2), 1);
                        else chk("latency", 32'(lat), 32'(e.lat));
                        chk("pulse_count", 32'(pulse_seen), 32'(e.npulse));
                        chk("pin_rules", 32'(pin_err), 0);
                    end
                    pulse_seen = 0;
                    pin_err = 1'b0;
                end
                if (!rsp_valid) rsp_seen = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] burns;
        logic [7:0]  d, init, rb0;
        logic [AW-1:0] a;
        bit          held;
        int          n;
        cmd_valid = 1'b0; cmd_address = '0; cmd_data = '0; rsp_ready = 1'b1;
        cmd_valid2 = 1'b0; cmd_address2 = '0; cmd_data2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_operation", 32'(operation), 32'(OP_READ));
        chk("reset_prog_bit", 32'(prog_bit), 0);
        chk("reset_address", 32'(address_line), 0);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_status", 32'(rsp_status), 0);
        chk("reset_rsp_readback", 32'(rsp_readback), 0);
        reset_n = 1'b1;

        issue(10'h05A, 8'hA5, 8'h00, 32'h11111111, 1'b1); wait_done();   // blank chip
        issue(10'h013, 8'h02, 8'h00, 32'h11111131, 1'b1); wait_done();   // bit 1 takes 3
        issue(10'h1FF, 8'h08, 8'h00, 32'h11110111, 1'b1); wait_done();   // bit 3 never burns
        issue(10'h044, 8'h01, 8'h11, 32'h11111111, 1'b1); wait_done();   // overblown
        issue(10'h045, 8'h11, 8'h11, 32'h11111111, 1'b1); wait_done();   // already programmed
        issue(10'h200, 8'hFF, 8'h00, 32'h11111111, 1'b1); wait_done();   // bad address

        for (int i = 0; i < 10; i++) begin
            a = ($urandom_range(0, 5) == 0) ? AW'(10'h200 + $urandom_range(0, 511))
                                            : AW'($urandom_range(0, 511));
            d = 8'($urandom);
            init = d & 8'($urandom);
            if ($urandom_range(0, 3) == 0) init = init | (8'h01 << $urandom_range(0, 7));
            burns = 32'h0;
            for (int b = 0; b < 8; b++) burns = burns | (32'($urandom_range(1, 2)) << (4 * b));
            if ($urandom_range(0, 3) == 0) burns = burns & ~(32'hF << (4 * $urandom_range(0, 7)));
            issue(a, d, init, burns, 1'b1);
            wait_done();
        end

        // Response held while the host stalls.
        rsp_ready = 1'b0;
        issue(10'h033, 8'h01, 8'h01, 32'h11111111, 1'b1);
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_seen", 32'(rsp_valid), 1);
        rb0 = rsp_readback;
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_status != STATUS_OK || cmd_ready || rsp_readback != rb0) held = 1'b0;
        end
        chk("hold_stable", 32'(held), 1);
        chk("hold_readback", 32'(rb0), 32'h01);
        rsp_ready = 1'b1;
        wait_done();

        // Reset in the middle of a pulse.
        issue(10'h0C3, 8'h01, 8'h00, 32'h11111111, 1'b0);
        n = 0;
        while (prog_bit == 8'h00 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_started", 32'(prog_bit), 32'h01);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midpulse_rst_operation", 32'(operation), 32'(OP_READ));
        chk("midpulse_rst_prog_bit", 32'(prog_bit), 0);
        chk("midpulse_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("midpulse_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("midpulse_rst_address", 32'(address_line), 0);
        @(negedge clk);
        exp_addr_line = '0;
        exp_pulse_q.delete();
        reset_n = 1'b1;
        issue(10'h0C3, 8'h81, 8'h01, 32'h11111111, 1'b1); wait_done();

        // 256x4 part: 0x100 is out of range.
        @(negedge clk);
        chk("p3601_ready", 32'(cmd_ready2), 1);
        cmd_address2 = 9'h100; cmd_data2 = 4'hF; cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        n = 0;
        while (!rsp_valid2 && n < 2) begin
            @(negedge clk);
            n++;
        end
        chk("p3601_bad_rsp_valid", 32'(rsp_valid2), 1);
        chk("p3601_bad_status", 32'(rsp_status2), 32'(STATUS_BAD_ADDR));
        chk("p3601_bad_readback", 32'(rsp_readback2), 0);
        repeat (4) @(negedge clk);
        chk("p3601_no_prog", 32'(prog2_seen), 0);
        chk("p3601_ready_again", 32'(cmd_ready2), 1);

        chk("exp_rsp_queue_empty", 32'(exp_q.size()), 0);
        chk("exp_pulse_queue_empty", 32'(exp_pulse_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
